// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the register-file/ALU datapath.
// Each accepted instruction walks READ -> EXEC -> WRITE and retires on the return to IDLE.
module datapath_ctrl #(
  parameter int unsigned numreg   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 8,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [4+3*numreg-1:0] instr,
  input  logic [DATA_W-1:0]     RES,
  output logic                  sel_mux,
  output logic [numreg-1:0]     selread1,
  output logic [numreg-1:0]     selread2,
  output logic [2:0]            sel_alu,
  output logic [numreg-1:0]     selwr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     result_q,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [2:0]          op_q, op_d;
  logic                mux_q, mux_d;
  logic [numreg-1:0]   rd_q, rd_d;
  logic [numreg-1:0]   rs1_q, rs1_d;
  logic [numreg-1:0]   rs2_q, rs2_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;
  logic                active;

  // Ready is registered so it stays low while reset is held and rises one edge after release.
  assign accept = instr_valid & ready_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mux_d   = mux_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    done_d  = 1'b0;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = instr[2:0];
          mux_d   = instr[3];
          rd_d    = instr[4 +: numreg];
          rs1_d   = instr[4+numreg +: numreg];
          rs2_d   = instr[4+2*numreg +: numreg];
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC: begin
        res_d   = RES;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      op_q    <= '0;
      mux_q   <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      op_q    <= op_d;
      mux_q   <= mux_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      done_q  <= done_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign active      = (state_q != S_IDLE);
  assign instr_ready = ready_q;
  assign busy        = active;
  assign sel_mux     = active ? mux_q : 1'b0;
  assign sel_alu     = active ? op_q  : '0;
  assign selread1    = active ? rs1_q : '0;
  assign selread2    = active ? rs2_q : '0;
  assign selwr       = (state_q == S_WRITE) ? rd_q : '0;
  assign wr_en       = (state_q == S_WRITE) && !(ZERO_REG && (rd_q == '0));
  assign done        = done_q;
  assign result_q    = res_q;
  assign retired     = cnt_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: default instance plus a CNT_W=2, ZERO_REG=0 instance on shared stimulus.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [18:0] instr;
  logic [7:0]  RES;

  logic       instr_ready, sel_mux, wr_en, busy, done;
  logic [4:0] selread1, selread2, selwr;
  logic [2:0] sel_alu;
  logic [7:0] result_q, retired;

  logic       instr_ready2, sel_mux2, wr_en2, busy2, done2;
  logic [4:0] selread1_2, selread2_2, selwr2;
  logic [2:0] sel_alu2;
  logic [7:0] result_q2;
  logic [1:0] retired2;

  always #5 clk = ~clk;

  datapath_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .RES(RES), .sel_mux(sel_mux), .selread1(selread1), .selread2(selread2), .sel_alu(sel_alu),
    .selwr(selwr), .wr_en(wr_en), .busy(busy), .done(done), .result_q(result_q), .retired(retired)
  );

  datapath_ctrl #(.CNT_W(2), .ZERO_REG(1'b0)) dut2 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready2), .instr(instr),
    .RES(RES), .sel_mux(sel_mux2), .selread1(selread1_2), .selread2(selread2_2), .sel_alu(sel_alu2),
    .selwr(selwr2), .wr_en(wr_en2), .busy(busy2), .done(done2), .result_q(result_q2), .retired(retired2)
  );

  typedef struct {
    logic [2:0] op;
    logic       mux;
    logic [4:0] rd, rs1, rs2;
    logic [7:0] res;
    logic [7:0] ret;
    logic [1:0] ret2;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_ret  = '0;
  logic [1:0] exp_ret2 = '0;

  // Observations captured by send() in each phase of one instruction.
  logic [4:0] o_rd_s1, o_rd_s2, o_rd_selwr, o_wr_selwr;
  logic [2:0] o_rd_alu;
  logic       o_rd_mux, o_rd_busy, o_rd_wr, o_rd_done, o_ex_wr, o_ex_busy, o_wr_en, o_wr_en2;
  logic       o_dn_done, o_dn_ready, o_dn_busy, o_dn_wr;
  logic [7:0] o_dn_res, o_dn_ret;
  logic [1:0] o_dn_ret2;

  function automatic logic [18:0] mk(input logic [2:0] op, input logic mux, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {rs2, rs1, rd, mux, op};
  endfunction

  // Drives one instruction from the IDLE cycle through to its retire cycle; pushes the expectation.
  task automatic send(input logic [18:0] ins, input logic [7:0] res, input bit hold);
    txn_t t;
    t.op = ins[2:0]; t.mux = ins[3]; t.rd = ins[8:4]; t.rs1 = ins[13:9]; t.rs2 = ins[18:14];
    t.res = res;
    exp_ret  = exp_ret + 8'd1;
    exp_ret2 = exp_ret2 + 2'd1;
    t.ret = exp_ret; t.ret2 = exp_ret2;
    sb.push_back(t);
    instr_valid = 1'b1; instr = ins; RES = res ^ 8'h3C;
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    instr = 19'($urandom);
    o_rd_s1 = selread1; o_rd_s2 = selread2; o_rd_alu = sel_alu; o_rd_mux = sel_mux;
    o_rd_busy = busy; o_rd_wr = wr_en; o_rd_selwr = selwr; o_rd_done = done;
    @(posedge clk); #1;
    RES = res;
    o_ex_wr = wr_en; o_ex_busy = busy;
    @(posedge clk); #1;
    RES = res ^ 8'hFF;
    o_wr_en = wr_en; o_wr_en2 = wr_en2; o_wr_selwr = selwr;
    @(posedge clk); #1;
    o_dn_done = done; o_dn_res = result_q; o_dn_ret = retired; o_dn_ret2 = retired2;
    o_dn_ready = instr_ready; o_dn_busy = busy; o_dn_wr = wr_en;
  endtask

  task automatic test_reset;
    rst = 1'b0; instr_valid = 1'b1; instr = mk(3'd7, 1'b1, 5'd9, 5'd9, 5'd9); RES = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", instr_ready); end
      checks++; if ({busy, wr_en, done, sel_mux} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, wr_en, done, sel_mux}); end
      checks++; if ({selread1, selread2, selwr, sel_alu} !== 18'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", {selread1, selread2, selwr, sel_alu}); end
      checks++; if ({result_q, retired} !== 16'h0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {result_q, retired}); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", instr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", busy); end
    instr_valid = 1'b0;
  endtask

  task automatic test_basic;
    txn_t t;
    send(mk(3'd0, 1'b0, 5'd2, 5'd0, 5'd1), 8'h5A, 1'b0);
    send(mk(3'd5, 1'b1, 5'd31, 5'd17, 5'd9), 8'hA7, 1'b0);
    for (int i = 0; i < 2; i++) begin
      t = sb.pop_front();
      if (i == 1) begin
        checks++; if (o_rd_s1 !== t.rs1) begin failures++; $display("FAIL basic_selread1 got=%0d exp=%0d", o_rd_s1, t.rs1); end
        checks++; if (o_rd_s2 !== t.rs2) begin failures++; $display("FAIL basic_selread2 got=%0d exp=%0d", o_rd_s2, t.rs2); end
        checks++; if (o_rd_alu !== t.op) begin failures++; $display("FAIL basic_sel_alu got=%0d exp=%0d", o_rd_alu, t.op); end
        checks++; if (o_rd_mux !== t.mux) begin failures++; $display("FAIL basic_sel_mux got=%b exp=%b", o_rd_mux, t.mux); end
        checks++; if ({o_rd_busy, o_rd_wr, o_rd_selwr, o_rd_done} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin failures++; $display("FAIL basic_read_flags got=%b%b%h%b exp=10000", o_rd_busy, o_rd_wr, o_rd_selwr, o_rd_done); end
        checks++; if ({o_ex_busy, o_ex_wr} !== 2'b10) begin failures++; $display("FAIL basic_exec got=%b%b exp=10", o_ex_busy, o_ex_wr); end
        checks++; if (o_wr_en !== 1'b1 || o_wr_selwr !== t.rd) begin failures++; $display("FAIL basic_write got=%b/%0d exp=1/%0d", o_wr_en, o_wr_selwr, t.rd); end
        checks++; if (o_dn_done !== 1'b1 || o_dn_busy !== 1'b0 || o_dn_wr !== 1'b0) begin failures++; $display("FAIL basic_retire got=%b%b%b exp=100", o_dn_done, o_dn_busy, o_dn_wr); end
        checks++; if (o_dn_res !== t.res) begin failures++; $display("FAIL basic_result got=%h exp=%h", o_dn_res, t.res); end
        checks++; if (o_dn_ret !== t.ret) begin failures++; $display("FAIL basic_retired got=%0d exp=%0d", o_dn_ret, t.ret); end
        checks++; if (o_dn_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", o_dn_ready); end
      end
    end
    // The first instruction's phases were overwritten; re-run the spec example alone and check it.
    send(mk(3'd0, 1'b0, 5'd2, 5'd0, 5'd1), 8'h5A, 1'b0);
    t = sb.pop_front();
    checks++; if ({o_rd_s1, o_rd_s2} !== {t.rs1, t.rs2}) begin failures++; $display("FAIL ex_selread got=%0d,%0d exp=%0d,%0d", o_rd_s1, o_rd_s2, t.rs1, t.rs2); end
    checks++; if (o_wr_en !== 1'b1 || o_wr_selwr !== 5'd2) begin failures++; $display("FAIL ex_write got=%b/%0d exp=1/2", o_wr_en, o_wr_selwr); end
    checks++; if (o_dn_done !== 1'b1 || o_dn_res !== 8'h5A) begin failures++; $display("FAIL ex_retire got=%b/%h exp=1/5a", o_dn_done, o_dn_res); end
    checks++; if (o_dn_ret !== t.ret) begin failures++; $display("FAIL ex_retired got=%0d exp=%0d", o_dn_ret, t.ret); end
  endtask

  task automatic test_zero_reg;
    txn_t t;
    send(mk(3'd3, 1'b1, 5'd0, 5'd4, 5'd7), 8'hC3, 1'b0);
    t = sb.pop_front();
    checks++; if ({o_rd_wr, o_ex_wr, o_wr_en, o_dn_wr} !== 4'b0) begin failures++; $display("FAIL zero_wr_en got=%b exp=0000", {o_rd_wr, o_ex_wr, o_wr_en, o_dn_wr}); end
    checks++; if (o_wr_en2 !== 1'b1) begin failures++; $display("FAIL zero_writable_r0 got=%b exp=1", o_wr_en2); end
    checks++; if (o_dn_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", o_dn_done); end
    checks++; if (o_dn_ret !== t.ret) begin failures++; $display("FAIL zero_retired got=%0d exp=%0d", o_dn_ret, t.ret); end
    checks++; if (o_dn_res !== t.res) begin failures++; $display("FAIL zero_result got=%h exp=%h", o_dn_res, t.res); end
  endtask

  task automatic test_back_to_back;
    txn_t t;
    int   dones = 0;
    logic [18:0] prog [3];
    logic [7:0]  vals [3];
    prog[0] = mk(3'd1, 1'b0, 5'd3, 5'd5, 5'd6);  vals[0] = 8'h11;
    prog[1] = mk(3'd2, 1'b1, 5'd4, 5'd7, 5'd8);  vals[1] = 8'h22;
    prog[2] = mk(3'd6, 1'b0, 5'd10, 5'd11, 5'd12); vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      send(prog[i], vals[i], 1'b1);
      t = sb.pop_front();
      dones += int'(o_dn_done);
      checks++; if (o_rd_busy !== 1'b1 || o_rd_done !== 1'b0) begin failures++; $display("FAIL b2b_accept%0d got=%b%b exp=10", i, o_rd_busy, o_rd_done); end
      checks++; if ({o_rd_s1, o_rd_s2, o_rd_alu} !== {t.rs1, t.rs2, t.op}) begin failures++; $display("FAIL b2b_fields%0d got=%h exp=%h", i, {o_rd_s1, o_rd_s2, o_rd_alu}, {t.rs1, t.rs2, t.op}); end
      checks++; if (o_wr_selwr !== t.rd || o_dn_res !== t.res) begin failures++; $display("FAIL b2b_wr_res%0d got=%0d/%h exp=%0d/%h", i, o_wr_selwr, o_dn_res, t.rd, t.res); end
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dones += int'(done);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle%0d got=%b exp=0", i, busy); end
    end
    checks++; if (dones !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
    checks++; if (retired !== exp_ret) begin failures++; $display("FAIL b2b_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_reset_mid;
    instr_valid = 1'b1; instr = mk(3'd1, 1'b0, 5'd5, 5'd2, 5'd3); RES = 8'h00;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || wr_en !== 1'b0) begin failures++; $display("FAIL rmid_exec got=%b%b exp=10", busy, wr_en); end
    rst = 1'b0; RES = 8'hA5;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_ret = '0; exp_ret2 = '0;
    checks++; if ({busy, wr_en, done, selwr} !== 8'h0) begin failures++; $display("FAIL rmid_idle got=%b%b%b%h exp=0", busy, wr_en, done, selwr); end
    checks++; if (result_q !== 8'h00 || retired !== exp_ret) begin failures++; $display("FAIL rmid_regs got=%h/%0d exp=00/0", result_q, retired); end
    @(posedge clk); #1;
    checks++; if (instr_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_after got=%b%b%b exp=100", instr_ready, wr_en, busy); end
  endtask

  task automatic test_wrap;
    txn_t t;
    logic [1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      send(mk(3'(i), 1'(i), 5'(i + 1), 5'(2 * i), 5'(3 * i)), 8'(8'h40 + i), 1'b0);
      t = sb.pop_front();
      checks++; if (o_dn_ret2 !== want[i] || o_dn_ret2 !== t.ret2) begin failures++; $display("FAIL wrap_retired%0d got=%0d exp=%0d", i, o_dn_ret2, want[i]); end
      checks++; if (o_dn_ret !== t.ret) begin failures++; $display("FAIL wrap_retired8_%0d got=%0d exp=%0d", i, o_dn_ret, t.ret); end
      checks++; if (result_q2 !== t.res) begin failures++; $display("FAIL wrap_result%0d got=%h exp=%h", i, result_q2, t.res); end
    end
  endtask

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instr = '0; RES = '0;
    test_reset();
    test_basic();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
